// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and coordinate type for the VGA timing generator.
package vga_timing_pkg;

   localparam int H_VISIBLE_DFLT = 640;
   localparam int H_FP_DFLT      = 16;
   localparam int H_SYNC_DFLT    = 96;
   localparam int H_BP_DFLT      = 48;
   localparam int H_TOTAL_DFLT   = H_VISIBLE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;

   localparam int V_VISIBLE_DFLT = 480;
   localparam int V_FP_DFLT      = 10;
   localparam int V_SYNC_DFLT    = 2;
   localparam int V_BP_DFLT      = 33;
   localparam int V_TOTAL_DFLT   = V_VISIBLE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active flags
// derived from the next count, so they line up with the count they describe.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DFLT,
   parameter int FP      = H_FP_DFLT,
   parameter int SYNC    = H_SYNC_DFLT,
   parameter int BP      = H_BP_DFLT
) (
   input  logic   vga_clk,
   input  logic   reset,
   input  logic   advance,
   output coord_t count,
   output logic   wrap,
   output logic   sync_n,
   output logic   active
);

   localparam int TOTAL = VISIBLE + FP + SYNC + BP;

   if (TOTAL > (1 << COORD_W)) begin : g_total_chk
      $error("vga_axis_counter: TOTAL %0d does not fit the coordinate width", TOTAL);
   end

   localparam coord_t LAST    = coord_t'(TOTAL - 1);
   localparam coord_t VIS_END = coord_t'(VISIBLE);
   localparam coord_t SYNC_LO = coord_t'(VISIBLE + FP);
   localparam coord_t SYNC_HI = coord_t'(VISIBLE + FP + SYNC);

   coord_t count_nxt;

   always_comb begin
      wrap      = advance && (count == LAST);
      count_nxt = count;
      if (wrap)         count_nxt = '0;
      else if (advance) count_nxt = count + coord_t'(1);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         count  <= '0;
         sync_n <= 1'b1;
         active <= 1'b1;
      end else begin
         count  <= count_nxt;
         sync_n <= !((count_nxt >= SYNC_LO) && (count_nxt < SYNC_HI));
         active <= (count_nxt < VIS_END);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY, blank, hs/vs and frame markers on vga_clk.
// Define VGA_TIMING_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DFLT,
   parameter int H_FP      = H_FP_DFLT,
   parameter int H_SYNC    = H_SYNC_DFLT,
   parameter int H_BP      = H_BP_DFLT,
   parameter int V_VISIBLE = V_VISIBLE_DFLT,
   parameter int V_FP      = V_FP_DFLT,
   parameter int V_SYNC    = V_SYNC_DFLT,
   parameter int V_BP      = V_BP_DFLT
) (
   input  logic   vga_clk,
   input  logic   reset,
   output coord_t DrawX,
   output coord_t DrawY,
   output logic   hs,
   output logic   vs,
   output logic   blank,
   output logic   sync,
   output logic   frame_start,
   output logic   line_end
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,output logic [15:0] frame_count
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;

   logic h_wrap, v_wrap, h_active, v_active;

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
   ) u_h (
      .vga_clk(vga_clk), .reset(reset), .advance(1'b1),
      .count(DrawX), .wrap(h_wrap), .sync_n(hs), .active(h_active)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
   ) u_v (
      .vga_clk(vga_clk), .reset(reset), .advance(h_wrap),
      .count(DrawY), .wrap(v_wrap), .sync_n(vs), .active(v_active)
   );

   assign blank    = h_active & v_active;
   assign sync     = 1'b0;
   assign line_end = (DrawX == coord_t'(H_TOTAL - 1));

   // Vertical wrap only fires on a horizontal wrap, so it alone marks the frame rollover.
   logic frame_wrap;
   assign frame_wrap = h_wrap & v_wrap;

   always_ff @(posedge vga_clk) begin
      if (reset) frame_start <= 1'b0;
      else       frame_start <= frame_wrap;
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   always_ff @(posedge vga_clk) begin
      if (reset)           frame_count <= '0;
      else if (frame_wrap) frame_count <= frame_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; expectations come from
// the elapsed-cycle count since the last reset.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int HV = 16, HF = 2, HS = 4, HB = 3;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FR = HT * VT;

   logic   vga_clk = 1'b0;
   logic   reset   = 1'b1;
   coord_t DrawX, DrawY;
   logic   hs, vs, blank, sync, frame_start, line_end;
`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .vga_clk(vga_clk), .reset(reset),
      .DrawX(DrawX), .DrawY(DrawY),
      .hs(hs), .vs(vs), .blank(blank), .sync(sync),
      .frame_start(frame_start), .line_end(line_end)
`ifdef VGA_TIMING_FRAME_COUNT_EN
     ,.frame_count(frame_count)
`endif
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int x; int y;
      bit hs; bit vs; bit blank; bit fs; bit le;
      int fc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   t     = 0;

   // Raster position is purely a function of cycles elapsed since reset.
   function automatic exp_t model(input int tt);
      exp_t e;
      e.x     = tt % HT;
      e.y     = (tt / HT) % VT;
      e.hs    = !((e.x >= HV + HF) && (e.x < HV + HF + HS));
      e.vs    = !((e.y >= VV + VF) && (e.y < VV + VF + VS));
      e.blank = (e.x < HV) && (e.y < VV);
      e.fs    = (tt > 0) && (tt % FR == 0);
      e.le    = (e.x == HT - 1);
      e.fc    = (tt / FR) % 65536;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit r);
      @(negedge vga_clk);
      reset = r;
      if (r) t = 0;
      else   t = t + 1;
      q.push_back(model(t));
   endtask

   // Monitor: one expectation per clock once the driver starts pushing.
   int blank_cnt = 0;
   bit in_frame  = 0;
   initial begin
      exp_t e;
      forever begin
         @(posedge vga_clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("DrawX", int'(DrawX), e.x);
            chk("DrawY", int'(DrawY), e.y);
            chk("hs", int'(hs), int'(e.hs));
            chk("vs", int'(vs), int'(e.vs));
            chk("blank", int'(blank), int'(e.blank));
            chk("sync", int'(sync), 0);
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("line_end", int'(line_end), int'(e.le));
`ifdef VGA_TIMING_FRAME_COUNT_EN
            chk("frame_count", int'(frame_count), e.fc);
`endif
            if (e.x == 0 && e.y == 0) begin
               if (e.fs && in_frame) chk("blank_per_frame", blank_cnt, HV * VV);
               blank_cnt = 0;
               in_frame  = 1;
            end
            if (blank) blank_cnt++;
         end
      end
   end

   initial begin
      repeat (3) step(1);
      repeat (3 * FR + 5) step(0);
      // Directed mid-frame reset, then a full frame to the next frame_start.
      while (!(t % FR == 7 * HT + 10)) step(0);
      step(1);
      repeat (FR + 3) step(0);
      repeat (3000) begin
         if ($urandom_range(0, 399) == 0) repeat ($urandom_range(1, 3)) step(1);
         else step(0);
      end
      repeat (3) @(posedge vga_clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the raster timing that sprite renderers consume: DrawX, DrawY, blank, and the hs/vs sync pulses for the VGA DAC. It is the producer end of the pixel-coordinate interface; every renderer's palette output gates on this block's blank. It sits at top level on vga_clk, the 25 MHz pixel clock, and fans out to all renderers.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum of the four = 525

Ports:
vga_clk  input  1  pixel clock; all logic on posedge
reset  input  1  synchronous, active-high
DrawX  output  10  horizontal counter, 0..H_TOTAL-1
DrawY  output  10  vertical counter, 0..V_TOTAL-1
hs  output  1  horizontal sync, active-low
vs  output  1  vertical sync, active-low
blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanked
sync  output  1  composite sync to DAC; constant 0
frame_start  output  1  one-cycle pulse at start of each new frame
line_end  output  1  high while DrawX==H_TOTAL-1

Behaviour:
- Interface: one clock (vga_clk); reset is synchronous and active-high.
- All outputs are registered. hs, vs, blank, frame_start and line_end are computed from the next-state counter values, so they align with DrawX/DrawY in the same cycle (zero skew).
- Reset values: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, sync=0, frame_start=0, line_end=0.
- Horizontal counter: increments by 1 each cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on a horizontal wrap. When a horizontal wrap occurs with DrawY==V_TOTAL-1, DrawY wraps to 0.
- hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults).
- vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults).
- frame_start=1 for exactly the one cycle in which (DrawX,DrawY) becomes (0,0) via a wrap from (H_TOTAL-1,V_TOTAL-1).
  - Not asserted on reset exit: (0,0) is reached by reset, not by a wrap.
- line_end is combinational on the registered DrawX and is high at the last pixel of every line, including blanked lines.
- Counter widths: 10 bits. Parameters must keep H_TOTAL and V_TOTAL <= 1024; a static assertion enforces this.
- Reset mid-frame: on the next edge both counters go to 0 and all outputs take their reset values. No partial frame_start is emitted.
- Frame period at defaults: 420000 cycles. Line period: 800 cycles.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments in the same cycle frame_start asserts, so frame_start and the new count are visible together.
  - Wraps 65535 -> 0.
  - Used for sprite animation stepping.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_/V_ VISIBLE, FP, SYNC, BP);
  - derived H_TOTAL and V_TOTAL;
  - localparam COORD_W=10;
  - typedef coord_t = logic [COORD_W-1:0].
- Sub-module vga_axis_counter, parameterized by VISIBLE/FP/SYNC/BP:
  - inputs: vga_clk, reset, advance;
  - outputs: count, wrap, sync_n, active.
  - Instanced twice. Horizontal: advance=1. Vertical: advance = horizontal wrap.
- The top combines the two instances' active flags into blank and their wraps into frame_start.

Test Plan:
- Reset held 3 cycles, then released -> DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0; after 1 cycle DrawX=1.
- Run 800 cycles from reset:
  - blank falls at DrawX=640;
  - hs low for DrawX 656..751 (96 cycles);
  - line_end high at DrawX=799;
  - DrawX returns to 0 with DrawY=1.
- Run a full frame (420000 cycles):
  - vs low exactly on lines 490 and 491 (1600 cycles total);
  - blank=0 on all lines >=480;
  - frame_start pulses once, at cycle 420000, coincident with (0,0).
- Assert reset at DrawX=300, DrawY=200 -> next edge (0,0), blank=1, frame_start=0; the following frame_start occurs 420000 cycles after reset deassertion.
- Check each visible pixel: blank==(DrawX<640 && DrawY<480) every cycle over two frames. Count of blank=1 cycles per frame = 307200.
- With VGA_TIMING_FRAME_COUNT_EN, run 3 frames -> frame_count steps 0->1->2->3, each increment in the frame_start cycle. Force the count to 65535 and complete one frame -> 0.
